// File: rtl/snake_pkg.sv
// Shared types for the snake body: grid coordinates, packed cell position and bitmap type.
package snake_pkg;

  localparam int GRID = 16;

  typedef logic [4:0] coord_t;

  typedef struct packed {
    coord_t i;
    coord_t j;
  } pos_t;

  typedef logic [15:0][15:0] grid_t;

  // A coordinate pair is on the board only when neither bit 4 is set.
  function automatic logic on_grid(pos_t p);
    return !p.i[4] && !p.j[4];
  endfunction

endpackage

// File: rtl/snake_body_seg_fifo.sv
// seg_fifo: circular buffer of body segments. Head is written at wr_ptr, tail is read
// combinationally at rd_ptr. Only pointers and count are reset; storage is not.
module seg_fifo
  import snake_pkg::*;
#(
  parameter int  DEPTH = 64,
  parameter type T     = pos_t
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  T                      din,
  output T                      tail,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  // Next-state pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Segment storage; when full, the write lands on the slot being popped this same cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  assign tail  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/snake_body.sv
// snake_body: ordered body segment list plus 16x16 occupancy bitmap for the snake game.
// Grows by INIT_LEN after reset and GROW_STEP per eaten pulse, otherwise shifts on tick.
// Optional feature macro: SNAKE_BODY_SCORE_EN adds an 8-bit saturating apple counter output.
module snake_body
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 64,
  parameter int INIT_LEN  = 3,
  parameter int GROW_STEP = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [4:0]                i_head,
  input  logic [4:0]                j_head,
  input  logic                      eaten,
  input  logic                      game_over,
  output logic [15:0][15:0]         GrnPixels,
  output logic [$clog2(MAX_LEN):0]  length,
  output logic                      full
`ifdef SNAKE_BODY_SCORE_EN
  ,
  output logic [7:0]                score
`endif
);

  localparam int             LW    = $clog2(MAX_LEN) + 1;
  localparam logic [LW-1:0]  MAX_L = LW'(MAX_LEN);
  localparam logic [LW:0]    STEP  = (LW+1)'(GROW_STEP);

  // Pending growth after an eaten pulse, clamped so it never exceeds the FIFO depth.
  function automatic logic [LW-1:0] sat_grow(logic [LW-1:0] gp);
    logic [LW:0] sum;
    sum = {1'b0, gp} + STEP;
    if (sum > {1'b0, MAX_L}) return MAX_L;
    return sum[LW-1:0];
  endfunction

  pos_t          head;
  pos_t          tail;
  logic          push;
  logic          pop;
  logic [LW-1:0] count;
  logic [LW-1:0] gp_q, gp_d;
  grid_t         grid_q, grid_d;

  assign head = {i_head, j_head};

  seg_fifo #(
    .DEPTH (MAX_LEN),
    .T     (pos_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (head),
    .tail  (tail),
    .count (count)
  );

  // Step decision: eaten increments first, then a valid tick either grows or shifts.
  // The tail clear is applied before the head set so a tail-chase keeps the cell lit.
  always_comb begin
    gp_d   = gp_q;
    grid_d = grid_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (!game_over) begin
      if (eaten) gp_d = sat_grow(gp_q);
      if (tick && on_grid(head)) begin
        push = 1'b1;
        if (gp_d != '0 && !full) begin
          gp_d = gp_d - 1'b1;
        end else if (count != '0) begin
          pop = 1'b1;
          if (on_grid(tail)) grid_d[tail.i[3:0]][tail.j[3:0]] = 1'b0;
        end
        grid_d[i_head[3:0]][j_head[3:0]] = 1'b1;
      end
    end
  end

  // Growth credit and bitmap registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gp_q   <= LW'(INIT_LEN);
      grid_q <= '0;
    end else begin
      gp_q   <= gp_d;
      grid_q <= grid_d;
    end
  end

  assign GrnPixels = grid_q;
  assign length    = count;
  assign full      = (count == MAX_L);

`ifdef SNAKE_BODY_SCORE_EN
  logic [7:0] score_q, score_d;

  // Apples eaten since reset, saturating at 255 and frozen on game over.
  always_comb begin
    score_d = score_q;
    if (eaten && !game_over && score_q != 8'hFF) score_d = score_q + 8'd1;
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body built with MAX_LEN=4 so the full/wrap paths are reached.
module tb_snake_body;
  import snake_pkg::*;

  localparam int MAXL = 4;
  localparam int INIT = 3;
  localparam int GS   = 1;
  localparam int LW   = $clog2(MAXL) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic [4:0]    i_head = '0;
  logic [4:0]    j_head = '0;
  logic          eaten = 1'b0;
  logic          game_over = 1'b0;
  grid_t         GrnPixels;
  logic [LW-1:0] length;
  logic          full;
`ifdef SNAKE_BODY_SCORE_EN
  logic [7:0]    score;
`endif

  snake_body #(
    .MAX_LEN   (MAXL),
    .INIT_LEN  (INIT),
    .GROW_STEP (GS)
  ) dut (
`ifdef SNAKE_BODY_SCORE_EN
    .score     (score),
`endif
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .i_head    (i_head),
    .j_head    (j_head),
    .eaten     (eaten),
    .game_over (game_over),
    .GrnPixels (GrnPixels),
    .length    (length),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    grid_t         g;
    logic [LW-1:0] len;
    logic          fl;
    logic [7:0]    sc;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errs   = 0;

  // Reference body: a plain queue of cells, oldest first.
  pos_t  m_body[$];
  int    m_gp = INIT;
  grid_t m_grid = '0;
  int    m_sc = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one clock of stimulus and push the expected post-edge outputs.
  task automatic cyc(input logic t, input logic [4:0] i, input logic [4:0] j,
                     input logic e, input logic go, input logic r);
    pos_t p;
    exp_t x;
    @(negedge clk);
    tick = t; i_head = i; j_head = j; eaten = e; game_over = go; reset = r;
    if (r) begin
      m_body.delete();
      m_gp = INIT;
      m_grid = '0;
      m_sc = 0;
    end else if (!go) begin
      if (e) begin
        m_gp = (m_gp + GS > MAXL) ? MAXL : m_gp + GS;
        if (m_sc < 255) m_sc++;
      end
      if (t && !i[4] && !j[4]) begin
        if (m_gp > 0 && m_body.size() < MAXL) begin
          m_gp--;
        end else if (m_body.size() > 0) begin
          p = m_body.pop_front();
          m_grid[p.i[3:0]][p.j[3:0]] = 1'b0;
        end
        p.i = i;
        p.j = j;
        m_body.push_back(p);
        m_grid[i[3:0]][j[3:0]] = 1'b1;
      end
    end
    x.g   = m_grid;
    x.len = LW'(m_body.size());
    x.fl  = (m_body.size() == MAXL);
    x.sc  = 8'(m_sc);
    sbq.push_back(x);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT outputs just after every edge that has a pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("sb_grid", 256'(GrnPixels), 256'(x.g));
        chk("sb_length", 256'(length), 256'(x.len));
        chk("sb_full", 256'(full), 256'(x.fl));
`ifdef SNAKE_BODY_SCORE_EN
        chk("sb_score", 256'(score), 256'(x.sc));
`endif
      end
    end
  end

  initial begin
    // Reset state
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("rst_length", 256'(length), 256'd0);
    chk("rst_grid", 256'(GrnPixels), 256'd0);
    chk("rst_full", 256'(full), 256'd0);

    // Initial growth: three ticks along row 10
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'd10, 5'(7 + k), 1'b0, 1'b0, 1'b0);
      idle();
    end
    settle();
    chk("t1_length", 256'(length), 256'd3);
    chk("t1_row10", 256'(GrnPixels[10]), 256'h0380);

    // Shift two cells
    cyc(1'b1, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0);
    idle();
    cyc(1'b1, 5'd10, 5'd11, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t2_length", 256'(length), 256'd3);
    chk("t2_row10", 256'(GrnPixels[10]), 256'h0E00);

    // Eaten together with tick grows immediately
    cyc(1'b1, 5'd10, 5'd12, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t3_length", 256'(length), 256'd4);
    chk("t3_row10", 256'(GrnPixels[10]), 256'h1E00);
    chk("t3_full", 256'(full), 256'd1);
`ifdef SNAKE_BODY_SCORE_EN
    chk("t3_score", 256'(score), 256'd1);
`endif

    // Off-board head coordinates are ignored
    cyc(1'b1, 5'd16, 5'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd3, 5'd20, 1'b0, 1'b0, 1'b0);
    settle();
    chk("oob_row10", 256'(GrnPixels[10]), 256'h1E00);
    chk("oob_row3", 256'(GrnPixels[3]), 256'h0000);

    // Game over freezes everything
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 5'd0, 5'(k), (k < 2), 1'b1, 1'b0);
    end
    settle();
    chk("t4_length", 256'(length), 256'd4);
    chk("t4_row10", 256'(GrnPixels[10]), 256'h1E00);
    chk("t4_row0", 256'(GrnPixels[0]), 256'h0000);
`ifdef SNAKE_BODY_SCORE_EN
    chk("t4_score", 256'(score), 256'd1);
`endif
    idle();

    // Tail-chase around a 2x2 loop at full length
    cyc(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd6, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t6_cell55", 256'(GrnPixels[5][5]), 256'd1);
    chk("t6_row5", 256'(GrnPixels[5]), 256'h0060);
    chk("t6_row6", 256'(GrnPixels[6]), 256'h0060);
    chk("t6_row10", 256'(GrnPixels[10]), 256'h0000);
    chk("t6_length", 256'(length), 256'd4);

    // Saturated growth at maximum length
    for (int k = 0; k < 10; k++) cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 5'd2, 5'(k), 1'b0, 1'b0, 1'b0);
    settle();
    chk("t5_length", 256'(length), 256'd4);
    chk("t5_full", 256'(full), 256'd1);
    chk("t5_row2", 256'(GrnPixels[2]), 256'h00F0);
    chk("t5_popcount", 256'($countones(GrnPixels)), 256'd4);

    // Reset mid-growth, then regrowth from INIT_LEN
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd12, 5'd1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("t7_rst_grid", 256'(GrnPixels), 256'd0);
    chk("t7_rst_length", 256'(length), 256'd0);
    for (int k = 2; k < 6; k++) cyc(1'b1, 5'd12, 5'(k), 1'b0, 1'b0, 1'b0);
    settle();
    chk("t7_length", 256'(length), 256'd3);
    chk("t7_row12", 256'(GrnPixels[12]), 256'h0038);
    chk("t7_full", 256'(full), 256'd0);

    idle();
    idle();
    settle();
    chk("sb_drained", 256'(sbq.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
